// File: rtl/uart_packet_parser_if.sv
// Bundle of the receive strobe, the payload stream, status pulses and the ACK handshake.
// The parser uses the slave modport; the environment drives through master.
interface uart_packet_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int IW = $clog2(MAX_LEN);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    out_cmd;
  logic [IW-1:0] out_idx;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          pkt_ok;
  logic          pkt_err;
  logic [1:0]    err_code;
  logic          overrun;
  logic          busy;
  logic [7:0]    ack_data;
  logic          ack_start;
  logic          ack_busy;

  modport slave (
    input  rx_data, rx_valid, out_ready, ack_busy,
    output out_cmd, out_idx, out_data, out_valid, out_last,
    output pkt_ok, pkt_err, err_code, overrun, busy, ack_data, ack_start
  );

  modport master (
    output rx_data, rx_valid, out_ready, ack_busy,
    input  out_cmd, out_idx, out_data, out_valid, out_last,
    input  pkt_ok, pkt_err, err_code, overrun, busy, ack_data, ack_start
  );
endinterface

// File: rtl/uart_packet_parser.sv
// Framed packet parser (header, cmd, len, payload, XOR csum) that releases verified payloads as a stream.
// Define UART_PARSER_ACK_EN to generate an ACK (0x06) / NAK (0x15) byte request per packet result.
module uart_packet_parser #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 65000
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_packet_parser_if.slave bus
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = IW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    csum_q, csum_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [1:0]    err_now;
  logic [7:0]    buf_mem [MAX_LEN];
  logic [7:0]    rd_data_q;

  logic receiving, tmo_hit, too_long, csum_match, last_beat, fire, buf_we;
  logic pkt_ok, pkt_err, emitting;

  assign receiving  = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  // A byte arriving on the terminal count takes priority over the timeout.
  assign tmo_hit    = receiving && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign too_long   = {1'b0, bus.rx_data} > 9'(MAX_LEN);
  assign csum_match = (bus.rx_data == csum_q);
  assign emitting   = (state_q == S_EMIT);
  assign last_beat  = (({1'b0, rd_idx_q} + LW'(1)) == len_q);
  assign fire       = emitting && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == HEADER)) state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.rx_valid)  state_d = S_LEN;
        else if (tmo_hit)  state_d = S_IDLE;
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          if (too_long)                 state_d = S_IDLE;
          else if (bus.rx_data == 8'h0) state_d = S_CSUM;
          else                          state_d = S_PAYLOAD;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          if ((wr_idx_q + LW'(1)) == len_q) state_d = S_CSUM;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_CSUM: begin
        if (bus.rx_valid) begin
          if (csum_match && (len_q != '0)) state_d = S_EMIT;
          else                             state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (fire && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pkt_ok  = 1'b0;
    pkt_err = 1'b0;
    err_now = 2'd0;
    if (tmo_hit) begin
      pkt_err = 1'b1;
      err_now = 2'd3;
    end else if (bus.rx_valid && (state_q == S_LEN) && too_long) begin
      pkt_err = 1'b1;
      err_now = 2'd1;
    end else if (bus.rx_valid && (state_q == S_CSUM)) begin
      if (!csum_match) begin
        pkt_err = 1'b1;
        err_now = 2'd2;
      end else if (len_q == '0) begin
        pkt_ok = 1'b1;
      end
    end else if (fire && last_beat) begin
      pkt_ok = 1'b1;
    end
    bus.out_valid = emitting;
    bus.out_last  = emitting && last_beat;
    bus.out_cmd   = emitting ? cmd_q : 8'h0;
    bus.out_idx   = emitting ? rd_idx_q : '0;
    bus.out_data  = emitting ? rd_data_q : 8'h0;
    bus.overrun   = emitting && bus.rx_valid;
    bus.busy      = (state_q != S_IDLE);
    bus.pkt_ok    = pkt_ok;
    bus.pkt_err   = pkt_err;
    bus.err_code  = err_code_d;
  end

  always_comb begin
    cmd_d      = cmd_q;
    csum_d     = csum_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    buf_we     = 1'b0;
    err_code_d = pkt_err ? err_now : err_code_q;
    case (state_q)
      S_CMD: begin
        if (bus.rx_valid) begin
          cmd_d  = bus.rx_data;
          csum_d = bus.rx_data;
        end
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          csum_d   = csum_q ^ bus.rx_data;
          len_d    = LW'(bus.rx_data);
          wr_idx_d = '0;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          buf_we   = 1'b1;
          csum_d   = csum_q ^ bus.rx_data;
          wr_idx_d = wr_idx_q + LW'(1);
        end
      end
      S_CSUM:  rd_idx_d = '0;
      S_EMIT:  if (fire) rd_idx_d = rd_idx_q + IW'(1);
      default: ;
    endcase
    tmo_d = (receiving && !bus.rx_valid && (state_d == state_q)) ? tmo_q + TW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= 8'h0;
      csum_q     <= 8'h0;
      len_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      tmo_q      <= '0;
      err_code_q <= 2'd0;
    end else begin
      cmd_q      <= cmd_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
    end
  end

  // Read address is the next rd_idx, so the registered data lines up with the current beat.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_idx_q[IW-1:0]] <= bus.rx_data;
    rd_data_q <= buf_mem[rd_idx_d];
  end

`ifdef UART_PARSER_ACK_EN
  logic       ack_pend_q, ack_pend_d, ack_start;
  logic [7:0] ack_data_q, ack_data_d;

  always_comb begin
    ack_start  = ack_pend_q && !bus.ack_busy;
    ack_pend_d = ack_pend_q && !ack_start;
    ack_data_d = ack_data_q;
    if (pkt_ok) begin
      ack_pend_d = 1'b1;
      ack_data_d = 8'h06;
    end else if (pkt_err) begin
      ack_pend_d = 1'b1;
      ack_data_d = 8'h15;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend_q <= 1'b0;
      ack_data_q <= 8'h0;
    end else begin
      ack_pend_q <= ack_pend_d;
      ack_data_q <= ack_data_d;
    end
  end

  assign bus.ack_start = ack_start;
  assign bus.ack_data  = ack_data_q;
`else
  logic unused_ack_busy;
  assign unused_ack_busy = bus.ack_busy;
  assign bus.ack_start   = 1'b0;
  assign bus.ack_data    = 8'h0;
`endif
endmodule
